// File: rtl/iod_dly_line_ctrl.sv
// IOD delay-line controller: turns move/load commands into single-tap strobes,
// tracks the tap position, honours range limits and lets the line settle after
// every strobe.
module iod_dly_line_ctrl #(
  parameter int unsigned TAP_W      = 8,
  parameter int unsigned MAX_TAP    = 255,
  parameter int unsigned LOAD_TAP   = 1,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic             fab_clk_i,
  input  logic             arst_ni,
  // Command interface
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_load_i,
  input  logic             req_dir_i,
  input  logic [TAP_W-1:0] req_steps_i,
  // Status
  output logic             done_o,
  output logic             err_o,
  output logic             busy_o,
  output logic [TAP_W-1:0] tap_pos_o,
  // IOD delay-line control
  output logic             delay_line_move_o,
  output logic             delay_line_direction_o,
  output logic             delay_line_load_o,
  input  logic             delay_line_out_of_range_i
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMove,
    StSettle,
    StFin
  } state_e;

  localparam logic [TAP_W-1:0] MaxTap     = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] LoadTap    = TAP_W'(LOAD_TAP);
  localparam logic [TAP_W-1:0] TapOne     = TAP_W'(1);
  // Settle counter counts down to zero, so it starts one below the length.
  localparam logic [3:0]       SettleLast = 4'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] rem_q, rem_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  logic             at_limit;

  // Moving further in the captured direction would leave the legal range.
  assign at_limit = dir_q ? (tap_q == MaxTap) : (tap_q == '0);

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          err_d = 1'b0;
          if (req_load_i) begin
            // Clear leftovers of an abandoned move so the load ends in FIN.
            rem_d   = '0;
            state_d = StLoad;
          end else begin
            dir_d = req_dir_i;
            rem_d = req_steps_i;
            if (req_steps_i == '0) begin
              state_d = StFin;
            end else begin
              state_d = StMove;
            end
          end
        end
      end

      StLoad: begin
        tap_d   = LoadTap;
        cnt_d   = SettleLast;
        state_d = StSettle;
      end

      StMove: begin
        if (at_limit) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          tap_d   = dir_q ? (tap_q + TapOne) : (tap_q - TapOne);
          rem_d   = rem_q - TapOne;
          cnt_d   = SettleLast;
          state_d = StSettle;
        end
      end

      StSettle: begin
        if (delay_line_out_of_range_i) begin
          err_d = 1'b1;
        end
        if (cnt_q == 4'd0) begin
          // An out-of-range flag seen anywhere in this window abandons the rest.
          if (err_q || delay_line_out_of_range_i || (rem_q == '0)) begin
            state_d = StFin;
          end else begin
            state_d = StMove;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge fab_clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= StIdle;
      tap_q   <= LoadTap;
      rem_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from registered state only, so they are glitch-free
  // relative to the command inputs.
  always_comb begin
    req_ready_o            = (state_q == StIdle);
    busy_o                 = (state_q != StIdle);
    done_o                 = (state_q == StFin);
    err_o                  = err_q;
    tap_pos_o              = tap_q;
    delay_line_move_o      = (state_q == StMove) && !at_limit;
    delay_line_load_o      = (state_q == StLoad);
    delay_line_direction_o = dir_q;
  end

  // Strobes are mutually exclusive and always separated by a settle window.
  assert property (@(posedge fab_clk_i) disable iff (!arst_ni)
    !(delay_line_move_o && delay_line_load_o));
  assert property (@(posedge fab_clk_i) disable iff (!arst_ni)
    (delay_line_move_o || delay_line_load_o) |=> !(delay_line_move_o || delay_line_load_o));
  assert property (@(posedge fab_clk_i) disable iff (!arst_ni)
    tap_q <= MaxTap);

endmodule

// File: tb/tb_iod_dly_line_ctrl.sv
// Directed testbench for iod_dly_line_ctrl with default parameters
// (TAP_W=8, MAX_TAP=255, LOAD_TAP=1, SETTLE_CYC=4).
module tb_iod_dly_line_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_load = 1'b0;
  logic       req_dir = 1'b0;
  logic [7:0] req_steps = 8'd0;
  logic       done_o;
  logic       err_o;
  logic       busy_o;
  logic [7:0] tap_o;
  logic       move_o;
  logic       dir_o;
  logic       load_o;
  logic       oor = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Results collected by run_cmd.
  int         r_moves, r_loads, r_first, r_gap, r_lat, r_viol;
  logic       r_err, r_to;
  logic [7:0] r_tap;

  iod_dly_line_ctrl #(
    .TAP_W     (8),
    .MAX_TAP   (255),
    .LOAD_TAP  (1),
    .SETTLE_CYC(4)
  ) dut (
    .fab_clk_i                (clk),
    .arst_ni                  (rst_n),
    .req_valid_i              (req_valid),
    .req_ready_o              (req_ready),
    .req_load_i               (req_load),
    .req_dir_i                (req_dir),
    .req_steps_i              (req_steps),
    .done_o                   (done_o),
    .err_o                    (err_o),
    .busy_o                   (busy_o),
    .tap_pos_o                (tap_o),
    .delay_line_move_o        (move_o),
    .delay_line_direction_o   (dir_o),
    .delay_line_load_o        (load_o),
    .delay_line_out_of_range_i(oor)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Issue one command from IDLE and watch until DONE. Event times are given as
  // the clock edge (relative to the accepting edge) at which they are sampled.
  task automatic run_cmd(input logic ld, input logic dir, input logic [7:0] steps,
                         input int oor_after, input int bound);
    int   acc;
    int   last;
    logic prev;
    logic oor_pend;
    logic oor_on;
    r_moves = 0; r_loads = 0; r_first = -1; r_gap = -1; r_lat = -1; r_viol = 0;
    r_err = 1'bx; r_tap = 8'hxx; r_to = 1'b1;
    last = 0; prev = 1'b0; oor_pend = 1'b0; oor_on = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_dir = dir; req_steps = steps;
    acc = cyc + 1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 1'b0;
      if (oor_on) begin oor = 1'b0; oor_on = 1'b0; end
      if (oor_pend) begin oor = 1'b1; oor_on = 1'b1; oor_pend = 1'b0; end
      if (move_o) begin
        r_moves++;
        if (r_first < 0) r_first = cyc + 1 - acc;
        else r_gap = cyc - last;
        last = cyc;
        if (oor_after != 0 && r_moves == oor_after) oor_pend = 1'b1;
      end
      if (load_o) begin
        r_loads++;
        if (r_first < 0) r_first = cyc + 1 - acc;
      end
      if ((move_o && load_o) || ((move_o || load_o) && prev)) r_viol++;
      prev = move_o || load_o;
      if (done_o) begin
        r_lat = cyc + 1 - acc;
        r_err = err_o;
        r_tap = tap_o;
        r_to  = 1'b0;
        break;
      end
    end
    oor = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    n_chk++; if (done_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL rst_done_err got=%b%b exp=00", done_o, err_o); end
    n_chk++; if (tap_o !== 8'd1) begin n_fail++; $display("FAIL rst_tap got=%0d exp=1", tap_o); end
    n_chk++; if ({move_o, load_o, dir_o} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes got=%b exp=000", {move_o, load_o, dir_o}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_move_up();
    run_cmd(1'b0, 1'b1, 8'd3, 0, 100);
    n_chk++; if (r_to !== 1'b0) begin n_fail++; $display("FAIL up3_timeout got=%b exp=0", r_to); end
    n_chk++; if (r_moves != 3) begin n_fail++; $display("FAIL up3_moves got=%0d exp=3", r_moves); end
    n_chk++; if (r_first != 1) begin n_fail++; $display("FAIL up3_first got=%0d exp=1", r_first); end
    n_chk++; if (r_gap != 5) begin n_fail++; $display("FAIL up3_gap got=%0d exp=5", r_gap); end
    n_chk++; if (r_lat != 16) begin n_fail++; $display("FAIL up3_latency got=%0d exp=16", r_lat); end
    n_chk++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL up3_err got=%b exp=0", r_err); end
    n_chk++; if (r_tap !== 8'd4) begin n_fail++; $display("FAIL up3_tap got=%0d exp=4", r_tap); end
    n_chk++; if (dir_o !== 1'b1) begin n_fail++; $display("FAIL up3_dir got=%b exp=1", dir_o); end
    n_chk++; if (r_viol != 0) begin n_fail++; $display("FAIL up3_strobe_spacing got=%0d exp=0", r_viol); end
  endtask

  task automatic test_zero_step();
    run_cmd(1'b0, 1'b1, 8'd0, 0, 20);
    n_chk++; if (r_to !== 1'b0) begin n_fail++; $display("FAIL zero_timeout got=%b exp=0", r_to); end
    n_chk++; if (r_moves + r_loads != 0) begin n_fail++; $display("FAIL zero_strobes got=%0d exp=0", r_moves + r_loads); end
    n_chk++; if (r_lat != 1) begin n_fail++; $display("FAIL zero_latency got=%0d exp=1", r_lat); end
    n_chk++; if (r_err !== 1'b0 || r_tap !== 8'd4) begin n_fail++; $display("FAIL zero_err_tap got=%b/%0d exp=0/4", r_err, r_tap); end
  endtask

  task automatic test_limit_low();
    run_cmd(1'b0, 1'b0, 8'd2, 0, 100);
    n_chk++; if (r_tap !== 8'd2 || r_lat != 11 || dir_o !== 1'b0) begin n_fail++; $display("FAIL down2 tap/lat/dir got=%0d/%0d/%b exp=2/11/0", r_tap, r_lat, dir_o); end
    run_cmd(1'b0, 1'b0, 8'd5, 0, 100);
    n_chk++; if (r_moves != 2) begin n_fail++; $display("FAIL down5_moves got=%0d exp=2", r_moves); end
    n_chk++; if (r_tap !== 8'd0) begin n_fail++; $display("FAIL down5_tap got=%0d exp=0", r_tap); end
    n_chk++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL down5_err got=%b exp=1", r_err); end
    n_chk++; if (r_lat != 12) begin n_fail++; $display("FAIL down5_latency got=%0d exp=12", r_lat); end
    @(negedge clk);
    n_chk++; if (err_o !== 1'b1 || done_o !== 1'b0) begin n_fail++; $display("FAIL down5_err_hold got=%b%b exp=10", err_o, done_o); end
  endtask

  task automatic test_load();
    run_cmd(1'b0, 1'b1, 8'd40, 0, 400);
    n_chk++; if (r_tap !== 8'd40 || r_err !== 1'b0) begin n_fail++; $display("FAIL up40 tap/err got=%0d/%b exp=40/0", r_tap, r_err); end
    run_cmd(1'b1, 1'b0, 8'd7, 0, 50);
    n_chk++; if (r_loads != 1 || r_moves != 0) begin n_fail++; $display("FAIL load_strobes got=%0d/%0d exp=1/0", r_loads, r_moves); end
    n_chk++; if (r_first != 1) begin n_fail++; $display("FAIL load_first got=%0d exp=1", r_first); end
    n_chk++; if (r_lat != 6) begin n_fail++; $display("FAIL load_latency got=%0d exp=6", r_lat); end
    n_chk++; if (r_tap !== 8'd1 || r_err !== 1'b0) begin n_fail++; $display("FAIL load tap/err got=%0d/%b exp=1/0", r_tap, r_err); end
    n_chk++; if (dir_o !== 1'b1) begin n_fail++; $display("FAIL load_dir_held got=%b exp=1", dir_o); end
  endtask

  task automatic test_limit_high();
    run_cmd(1'b0, 1'b1, 8'd255, 0, 3000);
    n_chk++; if (r_moves != 254) begin n_fail++; $display("FAIL up255_moves got=%0d exp=254", r_moves); end
    n_chk++; if (r_tap !== 8'd255 || r_err !== 1'b1) begin n_fail++; $display("FAIL up255 tap/err got=%0d/%b exp=255/1", r_tap, r_err); end
    n_chk++; if (r_lat != 1272) begin n_fail++; $display("FAIL up255_latency got=%0d exp=1272", r_lat); end
    run_cmd(1'b1, 1'b0, 8'd0, 0, 50);
    n_chk++; if (r_tap !== 8'd1 || r_err !== 1'b0) begin n_fail++; $display("FAIL reload tap/err got=%0d/%b exp=1/0", r_tap, r_err); end
  endtask

  task automatic test_out_of_range();
    run_cmd(1'b0, 1'b1, 8'd6, 2, 100);
    n_chk++; if (r_moves != 2) begin n_fail++; $display("FAIL oor_moves got=%0d exp=2", r_moves); end
    n_chk++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL oor_err got=%b exp=1", r_err); end
    n_chk++; if (r_tap !== 8'd3 || r_lat != 11) begin n_fail++; $display("FAIL oor tap/lat got=%0d/%0d exp=3/11", r_tap, r_lat); end
  endtask

  task automatic test_back_to_back();
    int acc;
    int rdy_busy;
    int lat;
    lat = -1; rdy_busy = 0;
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_dir = 1'b1; req_steps = 8'd2;
    acc = cyc + 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_o) begin lat = cyc + 1 - acc; break; end
      if (req_ready) rdy_busy++;
    end
    n_chk++; if (lat != 11) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=11", lat); end
    n_chk++; if (rdy_busy != 0) begin n_fail++; $display("FAIL b2b_ready_while_busy got=%0d exp=0", rdy_busy); end
    n_chk++; if (tap_o !== 8'd5) begin n_fail++; $display("FAIL b2b_tap1 got=%0d exp=5", tap_o); end
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept got=%b exp=1", busy_o); end
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_o) begin lat = i; break; end
    end
    n_chk++; if (lat < 0 || tap_o !== 8'd7) begin n_fail++; $display("FAIL b2b_second tap=%0d wait=%0d exp tap=7", tap_o, lat); end
  endtask

  task automatic test_reset_mid();
    int seen;
    int moves;
    int dones;
    seen = 0; moves = 0; dones = 0;
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_dir = 1'b1; req_steps = 8'd10;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 50 && seen < 2; i++) begin
      if (move_o) seen++;
      if (seen < 2) @(negedge clk);
    end
    n_chk++; if (seen != 2) begin n_fail++; $display("FAIL mid_two_moves got=%0d exp=2", seen); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if (busy_o !== 1'b0 || move_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_outputs busy/move/done got=%b%b%b exp=000", busy_o, move_o, done_o); end
    n_chk++; if (tap_o !== 8'd1 || dir_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst tap/dir got=%0d/%b exp=1/0", tap_o, dir_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready got=%b exp=1", req_ready); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (move_o) moves++;
      if (done_o) dones++;
    end
    n_chk++; if (moves != 0 || dones != 0) begin n_fail++; $display("FAIL mid_abandoned moves/dones got=%0d/%0d exp=0/0", moves, dones); end
    n_chk++; if (tap_o !== 8'd1) begin n_fail++; $display("FAIL mid_final_tap got=%0d exp=1", tap_o); end
  endtask

  initial begin
    test_reset();
    test_move_up();
    test_zero_step();
    test_limit_low();
    test_load();
    test_limit_high();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
